// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rising-to-rising period of an
// asynchronous pulse train in clk cycles, using saturating counters.
module pwm_capture #(
  parameter int unsigned CNT_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sig_i,
  output logic [CNT_WIDTH-1:0] high_cycles,
  output logic [CNT_WIDTH-1:0] period_cycles,
  output logic                 meas_valid,
  output logic                 overflow,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 s1_q, s2_q, s3_q;
  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_WIDTH-1:0] period_res_q, period_res_d;
  logic [CNT_WIDTH-1:0] high_res_q, high_res_d;
  logic                 meas_valid_q, meas_valid_d;
  logic                 overflow_q, overflow_d;

  logic rise, fall, cnt_sat;

  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  // high_cnt never exceeds period_cnt, so only the period counter is watched
  assign cnt_sat = (period_cnt_q == '1) && !rise;

  // Two-flop synchroniser plus delay flop for edge detection; ignores enable
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Capture FSM: arm on a rise, count through HIGH/LOW, publish on next rise
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    period_res_d = period_res_q;
    high_res_d   = high_res_q;
    meas_valid_d = 1'b0;
    overflow_d   = overflow_q;

    if (!enable) begin
      // enable low dominates everything, including a coincident rise
      state_d      = ST_IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      overflow_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          period_cnt_d = '0;
          high_cnt_d   = '0;
          if (rise) begin
            state_d      = ST_HIGH;
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (cnt_sat) begin
            overflow_d   = 1'b1;
            state_d      = ST_IDLE;
            period_cnt_d = '0;
            high_cnt_d   = '0;
          end else begin
            period_cnt_d = period_cnt_q + CNT_ONE;
            if (s2_q) high_cnt_d = high_cnt_q + CNT_ONE;
            if (fall) state_d = ST_LOW;
          end
        end
        ST_LOW: begin
          if (rise) begin
            period_res_d = period_cnt_q;
            high_res_d   = high_cnt_q;
            meas_valid_d = 1'b1;
            overflow_d   = 1'b0;
            state_d      = ST_HIGH;
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
          end else if (cnt_sat) begin
            overflow_d   = 1'b1;
            state_d      = ST_IDLE;
            period_cnt_d = '0;
            high_cnt_d   = '0;
          end else begin
            period_cnt_d = period_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          period_cnt_d = '0;
          high_cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      period_res_q <= '0;
      high_res_q   <= '0;
      meas_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_res_q <= period_res_d;
      high_res_q   <= high_res_d;
      meas_valid_q <= meas_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign high_cycles   = high_res_q;
  assign period_cycles = period_res_q;
  assign meas_valid    = meas_valid_q;
  assign overflow      = overflow_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures the high time and period of a PWM or other pulse train, in clk cycles. Sits directly downstream of the PWM generator in the uC block, either on a loop-back of pwm_o or on an external pin. Lets firmware confirm divider/compare programming and read back external PWM/servo signals. The input is asynchronous; it is synchronised, edge-detected and timed with saturating counters.

Parameters:
CNT_WIDTH, 24, width of the period/high-time counters and result registers (covers a 16-bit divider times 8-bit PWM).

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
enable  input  1  capture enable; low forces IDLE
sig_i  input  1  asynchronous signal under measurement
high_cycles  output  CNT_WIDTH  high time of the last complete period, in clk cycles
period_cycles  output  CNT_WIDTH  rising-to-rising period of the last complete period, in clk cycles
meas_valid  output  1  single-cycle pulse when high_cycles/period_cycles update
overflow  output  1  sticky flag: period counter saturated before the next rising edge
busy  output  1  high when state != IDLE

Behaviour:
- Reset: sync flops 0; state IDLE; counters 0; high_cycles=0; period_cycles=0; meas_valid=0; overflow=0; busy=0.
- Synchroniser: 2 flops, s1<=sig_i, s2<=s1. Delay flop s3<=s2. These run regardless of enable.
- Edge decode: rise = s2 & ~s3; fall = ~s2 & s3.
- "High cycle" = any cycle with s2=1.
- States: IDLE, HIGH, LOW.
- IDLE:
  - Counters held at 0.
  - On rise with enable=1: period_cnt<=1, high_cnt<=1, go to HIGH. No measurement is produced; this edge only arms capture.
  - No timeout in IDLE; a stuck input leaves the block idle.
- HIGH:
  - Each cycle: period_cnt++.
  - If s2=1: high_cnt++.
  - On fall: go to LOW.
- LOW:
  - Each non-rise cycle: period_cnt++.
  - On rise:
    - period_cycles<=period_cnt and high_cycles<=high_cnt, both registered.
    - meas_valid<=1 for exactly one cycle; overflow<=0.
    - period_cnt<=1, high_cnt<=1, go to HIGH. Capture is back-to-back; no edge is lost.
- Result: input with period P and high time H (both in clk cycles, stable) yields period_cycles=P and high_cycles=H.
- Latency: sig_i first sampled high at edge n → rise seen in the cycle after edge n+1 → meas_valid and results valid after edge n+2.
- Saturation:
  - If period_cnt is all-ones and the current cycle is not a rise: overflow<=1, state<=IDLE, counters<=0, no meas_valid.
  - high_cnt cannot exceed period_cnt, so it needs no separate check.
  - Covers stuck-high and stuck-low inputs. Recovery needs a fresh arming rise.
- overflow: stays set until the next meas_valid, enable low, or reset.
- enable low (any state, any cycle):
  - Next state IDLE, counters 0, meas_valid 0, overflow cleared.
  - high_cycles and period_cycles hold their last values.
  - A period in progress is discarded.
- enable rising while sig_i is already high: arming waits for the next genuine rise.
- Pulses shorter than 1 clk may be missed; the minimum measurable high/low time is 1 cycle each, so period >= 2.
- Rise and enable-low in the same cycle: enable wins, no measurement.
- Reset mid-period: everything returns to reset values within one cycle.
- Results and meas_valid are registered; no combinational path from sig_i to any output.

Test Plan:
1. Reset, enable=1, square wave period 10 high 3 → first rise arms only; meas_valid after 2nd rise with period_cycles=10, high_cycles=3; repeats every 10 cycles.
2. Drive from the pwm block with div=1, compare=63 (PWM_BITS=8) → period_cycles=512, high_cycles=128 on each meas_valid.
3. Period 2, high 1 (minimum) → period_cycles=2, high_cycles=1, meas_valid every 2 cycles.
4. CNT_WIDTH=8, arm, then hold sig_i high → overflow=1 after 255 counted cycles, busy=0, no meas_valid; next clean period-20 wave → overflow clears on its first meas_valid (period_cycles=20).
5. Drop enable mid-period, then restore → no meas_valid for the broken period, previous results held; a fresh arm is required before the next measurement.
6. Assert reset mid-HIGH → all outputs 0 the following cycle; resumes correctly after release.
